// File: rtl/wb_sequencer.sv
// ---------------------------------------------------------------------------
// wb_sequencer
//
// Purpose:
//   Write-back sequencer in front of the register file's single write port.
//   Producers push write-back requests into a small in-order FIFO through a
//   valid/ready handshake. The block issues at most one register write per
//   cycle. A two-result ("wide") op becomes two writes: the high result to r7
//   first, then the low result to r6. A per-register pending mask is exported
//   so the issue logic can detect hazards.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   W         data width
//
// Ports:
//   Clk        in   clock, all state updates on posedge
//   Reset_n    in   asynchronous active-low reset
//   ReqValid   in   write-back request present
//   ReqReady   out  request accepted this cycle if ReqValid is also high
//   ReqWide    in   two-result op (writes r7 then r6, ReqAddr ignored)
//   ReqAddr    in   destination register for a single write
//   ReqData    in   single-write data, or low (r6) result of a wide op
//   ReqDataHi  in   high (r7) result of a wide op
//   WriteEn    out  register-file write enable (registered)
//   Waddr      out  register-file write address (registered)
//   DataIn     out  register-file write data (registered)
//   Pending    out  bit r set while a queued or presented write targets r
//   Busy       out  FIFO non-empty, second half pending, or a write presented
// ---------------------------------------------------------------------------
module wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWide,
  input  logic [2:0]   ReqAddr,
  input  logic [W-1:0] ReqData,
  input  logic [W-1:0] ReqDataHi,
  output logic         WriteEn,
  output logic [2:0]   Waddr,
  output logic [W-1:0] DataIn,
  output logic [7:0]   Pending,
  output logic         Busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           we_q, we_d;
  logic [2:0]     waddr_q, waddr_d;
  logic [W-1:0]   data_q, data_d;

  // FIFO payload storage; validity is tracked by the pointers and count only.
  logic           fifo_wide [DEPTH];
  logic [2:0]     fifo_addr [DEPTH];
  logic [W-1:0]   fifo_data [DEPTH];
  logic [W-1:0]   fifo_hi   [DEPTH];

  logic           push;
  logic           pop;

  // No bypass: a full FIFO refuses even if the head is popping this cycle.
  assign ReqReady = (count_q < (AW+1)'(DEPTH)) && Reset_n;
  assign push     = ReqValid && ReqReady;

  // Issue FSM next-state. A wide head is read twice: r7 without popping,
  // then r6 from SECOND together with the pop.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          we_d = 1'b1;
          if (fifo_wide[rd_ptr_q]) begin
            waddr_d = 3'd7;
            data_d  = fifo_hi[rd_ptr_q];
            state_d = SECOND;
          end else begin
            waddr_d = fifo_addr[rd_ptr_q];
            data_d  = fifo_data[rd_ptr_q];
            pop     = 1'b1;
          end
        end
      end
      SECOND: begin
        we_d    = 1'b1;
        waddr_d = 3'd6;
        data_d  = fifo_data[rd_ptr_q];
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_wide[wr_ptr_q] <= ReqWide;
      fifo_addr[wr_ptr_q] <= ReqAddr;
      fifo_data[wr_ptr_q] <= ReqData;
      fifo_hi[wr_ptr_q]   <= ReqDataHi;
    end
  end

  // Pending mask: entry i counting from the head is live when i < count.
  // A wide head still in the FIFO keeps both r6 and r7 marked.
  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count_q) begin
        if (fifo_wide[rd_ptr_q + AW'(i)]) begin
          Pending[7:6] = 2'b11;
        end else begin
          Pending[fifo_addr[rd_ptr_q + AW'(i)]] = 1'b1;
        end
      end
    end
    if (we_q) begin
      Pending[waddr_q] = 1'b1;
    end
  end

  assign WriteEn = we_q;
  assign Waddr   = waddr_q;
  assign DataIn  = data_q;
  assign Busy    = (count_q != '0) || (state_q == SECOND) || we_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_sequencer
//
// Directed, self-checking bench for wb_sequencer (DEPTH=4, W=16). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so every check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_wb_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWide;
  logic [2:0]  ReqAddr;
  logic [15:0] ReqData;
  logic [15:0] ReqDataHi;
  logic        WriteEn;
  logic [2:0]  Waddr;
  logic [15:0] DataIn;
  logic [7:0]  Pending;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  wb_sequencer #(.DEPTH(4), .W(16)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWide   (ReqWide),
    .ReqAddr   (ReqAddr),
    .ReqData   (ReqData),
    .ReqDataHi (ReqDataHi),
    .WriteEn   (WriteEn),
    .Waddr     (Waddr),
    .DataIn    (DataIn),
    .Pending   (Pending),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // One vector: inputs held for one cycle, outputs expected after the edge.
  typedef struct {
    logic        valid;
    logic        wide;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] hi;
    logic        exp_we;
    logic [2:0]  exp_waddr;
    logic [15:0] exp_data;
    logic [7:0]  exp_pend;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wide,
                               input logic [2:0] addr, input logic [15:0] data,
                               input logic [15:0] hi);
    ReqValid  = valid;
    ReqWide   = wide;
    ReqAddr   = addr;
    ReqData   = data;
    ReqDataHi = hi;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Expected write stream for the backpressure test.
  logic [2:0]  exp_addr_q [$];
  logic [15:0] exp_data_q [$];

  initial begin
    // Single write, wide op, duplicate target, back-to-back singles.
    //             vld wide addr data      hi        we waddr data     pend   rdy busy
    vecs[0]  = '{1'b1, 1'b0, 3'd3, 16'h1234, 16'h0000, 1'b0, 3'd0, 16'h0000, 8'h08, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'h1234, 8'h08, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd3, 16'h1234, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3'd1, 16'h00AA, 16'hBEEF, 1'b0, 3'd3, 16'h1234, 8'hC0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'hBEEF, 8'hC0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd6, 16'h00AA, 8'h40, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd6, 16'h00AA, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd2, 16'h0001, 16'h0000, 1'b0, 3'd6, 16'h00AA, 8'h04, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'd2, 16'h0002, 16'h0000, 1'b1, 3'd2, 16'h0001, 8'h04, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd2, 16'h0002, 8'h04, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd2, 16'h0002, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'd1, 16'h1111, 16'h0000, 1'b0, 3'd2, 16'h0002, 8'h02, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 3'd5, 16'h5555, 16'h0000, 1'b1, 3'd1, 16'h1111, 8'h22, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd5, 16'h5555, 8'h20, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd5, 16'h5555, 8'h00, 1'b1, 1'b0};

    // Reset held with a request offered: nothing may be accepted.
    Reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd4, 16'hFFFF, 16'hFFFF);
    step();
    step();
    step();
    checkOutput("rst_we",      32'(WriteEn),  32'h0);
    checkOutput("rst_waddr",   32'(Waddr),    32'h0);
    checkOutput("rst_data",    32'(DataIn),   32'h0);
    checkOutput("rst_pending", 32'(Pending),  32'h0);
    checkOutput("rst_ready",   32'(ReqReady), 32'h0);
    checkOutput("rst_busy",    32'(Busy),     32'h0);
    Reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    #1;
    checkOutput("rel_ready",   32'(ReqReady), 32'h1);
    step();
    checkOutput("rel_busy",    32'(Busy),     32'h0);
    checkOutput("rel_pending", 32'(Pending),  32'h0);

    // Table-driven sequence.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].wide, vecs[i].addr, vecs[i].data, vecs[i].hi);
      checkOutput($sformatf("v%0d_ready", i), 32'(ReqReady), 32'(vecs[i].exp_ready));
      step();
      checkOutput($sformatf("v%0d_we", i),      32'(WriteEn), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d_waddr", i),   32'(Waddr),   32'(vecs[i].exp_waddr));
      checkOutput($sformatf("v%0d_data", i),    32'(DataIn),  32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d_pending", i), 32'(Pending), 32'(vecs[i].exp_pend));
      checkOutput($sformatf("v%0d_busy", i),    32'(Busy),    32'(vecs[i].exp_busy));
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);

    // Backpressure: six wide requests offered back-to-back, held until taken.
    begin
      int  sent      = 0;
      int  writes    = 0;
      int  occupancy = 0;
      int  cycles    = 0;
      bit  saw_full  = 0;
      bit  accepted;
      for (int j = 0; j < 6; j++) begin
        exp_addr_q.push_back(3'd7);
        exp_data_q.push_back(16'hA000 + 16'(j));
        exp_addr_q.push_back(3'd6);
        exp_data_q.push_back(16'h0B00 + 16'(j));
      end
      while ((sent < 6 || writes < 12) && cycles < 200) begin
        if (sent < 6) begin
          applyStimulus(1'b1, 1'b1, 3'd0, 16'h0B00 + 16'(sent), 16'hA000 + 16'(sent));
        end else begin
          applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        end
        checkOutput($sformatf("bp_ready_c%0d", cycles), 32'(ReqReady),
                    32'(occupancy < 4));
        if (occupancy == 4) saw_full = 1;
        accepted = ReqValid && ReqReady;
        step();
        cycles++;
        if (accepted) begin
          sent++;
          occupancy++;
        end
        if (WriteEn) begin
          if (exp_addr_q.size() == 0) begin
            checkOutput("bp_extra_write", 32'(Waddr), 32'hFFFF_FFFF);
          end else begin
            checkOutput($sformatf("bp_w%0d_addr", writes), 32'(Waddr),  32'(exp_addr_q.pop_front()));
            checkOutput($sformatf("bp_w%0d_data", writes), 32'(DataIn), 32'(exp_data_q.pop_front()));
          end
          if (Waddr == 3'd6) occupancy--;
          writes++;
        end
      end
      checkOutput("bp_timeout",  32'(cycles < 200), 32'h1);
      checkOutput("bp_writes",   32'(writes),       32'd12);
      checkOutput("bp_saw_full", 32'(saw_full),     32'h1);
      step();
      checkOutput("bp_busy_end", 32'(Busy),         32'h0);
      checkOutput("bp_pend_end", 32'(Pending),      32'h0);
    end

    // Reset while the r6 half of a wide op is still owed.
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h0BAD, 16'hCAFE);
    step();
    applyStimulus(1'b1, 1'b0, 3'd4, 16'h4444, 16'h0);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    checkOutput("mid_r7_we",    32'(WriteEn), 32'h1);
    checkOutput("mid_r7_addr",  32'(Waddr),   32'h7);
    checkOutput("mid_r7_data",  32'(DataIn),  32'hCAFE);
    checkOutput("mid_r7_pend",  32'(Pending), 32'hD0);
    Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_we",    32'(WriteEn),  32'h0);
    checkOutput("mid_rst_pend",  32'(Pending),  32'h0);
    checkOutput("mid_rst_busy",  32'(Busy),     32'h0);
    checkOutput("mid_rst_ready", 32'(ReqReady), 32'h0);
    step();
    step();
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("post_rst_we_c%0d", k),   32'(WriteEn), 32'h0);
      checkOutput($sformatf("post_rst_pend_c%0d", k), 32'(Pending), 32'h0);
      checkOutput($sformatf("post_rst_busy_c%0d", k), 32'(Busy),    32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
